// File: rtl/fpu_pkg.sv
// Shared FP datapath constants: default field widths and extended-mantissa layout.
package fpu_pkg;
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 24;
    localparam int STAGES    = 2;
    localparam int GRS_W     = 3;  // guard, round, sticky below the mantissa LSB
    localparam int S_BIT     = 0;

    // Extended mantissa: carry | mantissa | G R S
    function automatic int ext_w(input int man_w);
        return man_w + 1 + GRS_W;
    endfunction

    // Any shift at or beyond this pushes every mantissa bit into the sticky position
    function automatic int sh_sat(input int man_w);
        return man_w + GRS_W;
    endfunction
endpackage

// File: rtl/fpu_sticky_shr.sv
// Saturating logical right shift that ORs every shifted-out bit into the sticky LSB.
module fpu_sticky_shr
    import fpu_pkg::*;
#(
    parameter int EXT_W  = 28,
    parameter int SH_W   = 8,
    parameter int SH_SAT = 27
) (
    input  logic [EXT_W-1:0] din,
    input  logic [SH_W-1:0]  sh,
    output logic [EXT_W-1:0] dout
);
    logic [31:0]      sh_c;
    logic [EXT_W-1:0] shifted;
    logic [EXT_W-1:0] lost_mask;

    always_comb begin
        sh_c      = (32'(sh) >= 32'(SH_SAT)) ? 32'(SH_SAT) : 32'(sh);
        shifted   = din >> sh_c;
        lost_mask = ~({EXT_W{1'b1}} << sh_c);
        dout      = shifted;
        dout[S_BIT] = shifted[S_BIT] | (|(din & lost_mask));
    end
endmodule

// File: rtl/fpu_align_pipe.sv
// Exponent compare / mantissa align stage for FP add/sub: magnitude ordering in S1,
// sticky right-shift of the smaller operand in S2, valid/ready with full backpressure.
module fpu_align_pipe
    import fpu_pkg::*;
#(
    parameter  int EXP_W  = EXP_W_DEF,
    parameter  int MAN_W  = MAN_W_DEF,
    localparam int EXT_W  = ext_w(MAN_W),
    localparam int SH_SAT = sh_sat(MAN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_a_i,
    input  logic             sign_b_i,
    input  logic [EXP_W-1:0] exp_a_i,
    input  logic [EXP_W-1:0] exp_b_i,
    input  logic [MAN_W-1:0] mant_a_i,
    input  logic [MAN_W-1:0] mant_b_i,
    input  logic             op_sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_o,
    output logic [EXT_W-1:0] mant_l_o,
    output logic [EXT_W-1:0] mant_s_o,
    output logic             sign_o,
    output logic             eff_sub_o,
    output logic             swap_o
);
    logic [STAGES:1] vld_pipe;
    logic            adv1, adv2;

    assign adv2      = !vld_pipe[2] || out_ready;
    assign adv1      = !vld_pipe[1] || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];

    // S1: order by magnitude; equal magnitudes keep A on the L path
    logic             swap_c;
    logic [EXP_W-1:0] exp_l_c, exp_s_c;
    assign swap_c  = {exp_b_i, mant_b_i} > {exp_a_i, mant_a_i};
    assign exp_l_c = swap_c ? exp_b_i : exp_a_i;
    assign exp_s_c = swap_c ? exp_a_i : exp_b_i;

    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [MAN_W-1:0] s1_mant_l, s1_mant_s;
    logic             s1_sign, s1_eff, s1_swap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_exp      <= '0;
            s1_diff     <= '0;
            s1_mant_l   <= '0;
            s1_mant_s   <= '0;
            s1_sign     <= 1'b0;
            s1_eff      <= 1'b0;
            s1_swap     <= 1'b0;
        end else if (adv1) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1_exp    <= exp_l_c;
                s1_diff   <= exp_l_c - exp_s_c;
                s1_mant_l <= swap_c ? mant_b_i : mant_a_i;
                s1_mant_s <= swap_c ? mant_a_i : mant_b_i;
                s1_sign   <= swap_c ? (sign_b_i ^ op_sub_i) : sign_a_i;
                s1_eff    <= sign_a_i ^ sign_b_i ^ op_sub_i;
                s1_swap   <= swap_c;
            end
        end
    end

    // S2: align the smaller mantissa
    logic [EXT_W-1:0] mant_s_sh;

    fpu_sticky_shr #(
        .EXT_W (EXT_W),
        .SH_W  (EXP_W),
        .SH_SAT(SH_SAT)
    ) u_shr (
        .din ({1'b0, s1_mant_s, {GRS_W{1'b0}}}),
        .sh  (s1_diff),
        .dout(mant_s_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            exp_o       <= '0;
            mant_l_o    <= '0;
            mant_s_o    <= '0;
            sign_o      <= 1'b0;
            eff_sub_o   <= 1'b0;
            swap_o      <= 1'b0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                exp_o     <= s1_exp;
                mant_l_o  <= {1'b0, s1_mant_l, {GRS_W{1'b0}}};
                mant_s_o  <= mant_s_sh;
                sign_o    <= s1_sign;
                eff_sub_o <= s1_eff;
                swap_o    <= s1_swap;
            end
        end
    end
endmodule

// File: tb/tb_fpu_align_pipe.sv
// Directed + random check of fpu_align_pipe against a behavioural scoreboard model.
module tb_fpu_align_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        sign_a_i, sign_b_i, op_sub_i;
    logic [7:0]  exp_a_i, exp_b_i, exp_o;
    logic [23:0] mant_a_i, mant_b_i;
    logic [27:0] mant_l_o, mant_s_o;
    logic        sign_o, eff_sub_o, swap_o;

    fpu_align_pipe #(.EXP_W(8), .MAN_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign_a_i(sign_a_i), .sign_b_i(sign_b_i), .exp_a_i(exp_a_i), .exp_b_i(exp_b_i),
        .mant_a_i(mant_a_i), .mant_b_i(mant_b_i), .op_sub_i(op_sub_i),
        .out_valid(out_valid), .out_ready(out_ready), .exp_o(exp_o),
        .mant_l_o(mant_l_o), .mant_s_o(mant_s_o), .sign_o(sign_o),
        .eff_sub_o(eff_sub_o), .swap_o(swap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  e;
        logic [27:0] ml;
        logic [27:0] ms;
        logic        sg, es, sw;
    } res_t;

    res_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference: wide arithmetic, sticky from the shift remainder
    function automatic res_t model(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                                   input logic sb_, input logic [7:0] eb, input logic [23:0] mb,
                                   input logic op);
        res_t r;
        logic sw;
        int d;
        logic [63:0] x, q, rem;
        sw = ({eb, mb} > {ea, ma});
        d = sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
        x = 64'(sw ? ma : mb) * 64'd8;
        r.e  = sw ? eb : ea;
        r.ml = 28'(64'(sw ? mb : ma) * 64'd8);
        if (d >= 27) r.ms = {27'd0, x != 64'd0};
        else begin
            q   = x / (64'd1 << d);
            rem = x % (64'd1 << d);
            r.ms = q[27:0] | {27'd0, rem != 64'd0};
        end
        r.sg = sw ? (sb_ ^ op) : sa;
        r.es = sa ^ sb_ ^ op;
        r.sw = sw;
        return r;
    endfunction

    function automatic res_t dut_res();
        return {exp_o, mant_l_o, mant_s_o, sign_o, eff_sub_o, swap_o};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else if (out_ready) chk("out_pop", dut_res(), sb.pop_front());
            else chk("out_hold", dut_res(), sb[0]);
        end
    end

    task automatic drive(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                         input logic sb_, input logic [7:0] eb, input logic [23:0] mb,
                         input logic op);
        sign_a_i = sa; exp_a_i = ea; mant_a_i = ma;
        sign_b_i = sb_; exp_b_i = eb; mant_b_i = mb;
        op_sub_i = op; in_valid = 1'b1;
    endtask

    task automatic wait_accept(input int max_cyc);
        logic acc;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            if (acc) begin
                sb.push_back(model(sign_a_i, exp_a_i, mant_a_i, sign_b_i, exp_b_i, mant_b_i, op_sub_i));
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Single isolated transaction: checks latency plus spec-given constants
    task automatic send_chk(input string tag, input logic sa, input logic [7:0] ea,
                            input logic [23:0] ma, input logic sb_, input logic [7:0] eb,
                            input logic [23:0] mb, input logic op, input logic [7:0] want_e,
                            input logic [27:0] want_ml, input logic [27:0] want_ms,
                            input logic want_sw);
        int lat;
        @(posedge clk); #1;
        drive(sa, ea, ma, sb_, eb, mb, op);
        wait_accept(8);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_exp"}, exp_o, want_e);
        chk({tag, "_ml"}, mant_l_o, want_ml);
        chk({tag, "_ms"}, mant_s_o, want_ms);
        chk({tag, "_swap"}, swap_o, want_sw);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {exp_o, mant_l_o, mant_s_o, sign_o, eff_sub_o, swap_o}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        send_chk("t1", 0, 8'h82, 24'h800000, 0, 8'h80, 24'hC00000, 0, 8'h82, 28'h4000000, 28'h1800000, 0);
        chk("t1_eff", eff_sub_o, 0);
        send_chk("t2", 0, 8'h80, 24'h800000, 1, 8'h80, 24'hC00000, 0, 8'h80, 28'h6000000, 28'h4000000, 1);
        chk("t2_sign", sign_o, 1);
        chk("t2_eff", eff_sub_o, 1);
        send_chk("t3", 0, 8'h9E, 24'h800000, 0, 8'h80, 24'hC00001, 0, 8'h9E, 28'h4000000, 28'h0000001, 0);
        send_chk("t3z", 0, 8'h9E, 24'h800000, 0, 8'h80, 24'h000000, 0, 8'h9E, 28'h4000000, 28'h0000000, 0);
        send_chk("t4a", 0, 8'h83, 24'h800000, 0, 8'h80, 24'h800007, 0, 8'h83, 28'h4000000, 28'h0800007, 0);
        send_chk("t4b", 0, 8'h85, 24'h800000, 0, 8'h80, 24'h800007, 0, 8'h85, 28'h4000000, 28'h0200001, 0);
        send_chk("eq_mag", 1, 8'h90, 24'hABCDEF, 0, 8'h90, 24'hABCDEF, 1, 8'h90, 28'h55E6F78, 28'h55E6F78, 0);
        send_chk("diff27", 0, 8'h9B, 24'h800000, 0, 8'h80, 24'h800000, 0, 8'h9B, 28'h4000000, 28'h0000001, 0);
        drain("directed_drain");

        // Backpressure: two accepts fill the pipe, then in_ready must drop
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(0, 8'h81, 24'h812345, 0, 8'h80, 24'hF00001, 0); wait_accept(4);
        drive(1, 8'h70, 24'h900000, 0, 8'h75, 24'hA00003, 1); wait_accept(4);
        drive(0, 8'h40, 24'hFFFFFF, 1, 8'h40, 24'hFFFFFE, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(4);
        drive(0, 8'h01, 24'h000000, 1, 8'hFE, 24'h800000, 1); wait_accept(4);
        drain("bp_drain");

        // Async reset between edges with two items in flight
        @(posedge clk); #1;
        drive(0, 8'h88, 24'h800000, 0, 8'h86, 24'h900000, 0); wait_accept(4);
        drive(0, 8'h89, 24'h800000, 0, 8'h87, 24'h900000, 0); wait_accept(4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mant_l", mant_l_o, 0);
        sb.delete();
        #2 rst_n = 1'b1;
        send_chk("post_rst", 0, 8'h82, 24'h800000, 0, 8'h80, 24'hC00000, 0, 8'h82, 28'h4000000, 28'h1800000, 0);
        drain("rst_drain");

        // Random stream with random backpressure
        rnd_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 8'(8'h80 + $urandom_range(0, 40)),
                  ($urandom_range(0, 7) == 0) ? 24'h0 : (24'h800000 | 24'($urandom())),
                  1'($urandom_range(0, 1)), 8'(8'h80 + $urandom_range(0, 40)),
                  ($urandom_range(0, 7) == 0) ? 24'h0 : (24'h800000 | 24'($urandom())),
                  1'($urandom_range(0, 1)));
            wait_accept(20);
        end
        rnd_ready = 1'b0;
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
